// File: rtl/rom_streamer_if.sv
// Stream and control bundle between rom_streamer and its environment.
// master: the streamer (drives rom_addr, out_data/out_valid, busy, done).
// slave: the controller/consumer/ROM side (drives start, abort, base, len, rom_dout, out_ready).
interface rom_streamer_if #(
  parameter int Nloc  = 16,
  parameter int Dbits = 4
);
  localparam int AW = $clog2(Nloc);
  localparam int LW = $clog2(Nloc) + 1;

  logic             start;
  logic             abort;
  logic [AW-1:0]    base;
  logic [LW-1:0]    len;
  logic [AW-1:0]    rom_addr;
  logic [Dbits-1:0] rom_dout;
  logic [Dbits-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  modport master (
    input  start, abort, base, len, rom_dout, out_ready,
    output rom_addr, out_data, out_valid, busy, done
  );

  modport slave (
    output start, abort, base, len, rom_dout, out_ready,
    input  rom_addr, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/rom_streamer.sv
// Streams len words from an async-read ROM starting at base, wrapping past Nloc-1 to 0.
// Latency: first word valid on the edge after the start edge, then 1 word/cycle.
// Backpressure: out_data/out_valid hold while out_ready is low; abort drops the burst at once.
// Ports: clk, reset_n (async, active low); bus (master modport): start/abort/base/len control,
//        rom_addr/rom_dout ROM port, out_data/out_valid/out_ready stream, busy/done status.
module rom_streamer #(
  parameter int Nloc  = 16,
  parameter int Dbits = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  rom_streamer_if.master bus
);
  localparam int AW = $clog2(Nloc);
  localparam int LW = $clog2(Nloc) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [LW-1:0]    rem_q, rem_d;
  logic [Dbits-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic             done_q, done_d;

  // The output slot is free this cycle: either empty or its word is being accepted.
  logic slot_free;
  logic load;

  assign slot_free = !vld_q || bus.out_ready;
  assign load      = (rem_q != '0) && slot_free;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    if (bus.abort) begin
      // Abort wins over start and over any handshake this cycle; ptr and data hold.
      state_d = IDLE;
      vld_d   = 1'b0;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.len == '0) begin
              done_d = 1'b1;
            end else begin
              ptr_d   = bus.base;
              rem_d   = bus.len;
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (load) begin
            data_d = bus.rom_dout;
            vld_d  = 1'b1;
            rem_d  = rem_q - LW'(1);
            ptr_d  = (ptr_q == AW'(Nloc - 1)) ? '0 : ptr_q + AW'(1);
          end else if (slot_free) begin
            // Nothing left to fetch and the last word is gone (or was never pending).
            vld_d   = 1'b0;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // rom_addr comes straight from the pointer register, never from start/base/len.
  assign bus.rom_addr  = ptr_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = vld_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_rom_streamer.sv
module tb_rom_streamer;
  localparam int NLOC = 16;
  localparam int DB   = 4;
  localparam int AW   = $clog2(NLOC);
  localparam int LW   = $clog2(NLOC) + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rom_streamer_if #(.Nloc(NLOC), .Dbits(DB)) bus();

  rom_streamer #(.Nloc(NLOC), .Dbits(DB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [DB-1:0] rom [NLOC];
  initial for (int i = 0; i < NLOC; i++) rom[i] = DB'(i);
  assign bus.rom_dout = rom[bus.rom_addr];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a burst is (base, len); k words fetched so far.
  int m_run = 0, m_base = 0, m_len = 0, m_k = 0;
  int m_addr = 0, m_data = 0, m_valid = 0, m_done = 0;
  int m_ov;
  int exp_q[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run = 0; m_len = 0; m_k = 0; m_addr = 0; m_data = 0; m_valid = 0; m_done = 0;
      exp_q.delete();
    end else begin
      m_ov = m_valid;
      m_done = 0;
      if (bus.abort) begin
        m_run = 0; m_valid = 0; m_len = 0; m_k = 0;
        exp_q.delete();
      end else if (m_run == 0) begin
        if (bus.start) begin
          if (bus.len == '0) m_done = 1;
          else begin
            m_run = 1; m_base = int'(bus.base); m_len = int'(bus.len); m_k = 0; m_addr = m_base;
            for (int i = 0; i < m_len; i++) exp_q.push_back(int'(rom[(m_base + i) % NLOC]));
          end
        end
      end else if (m_ov == 0 || bus.out_ready) begin
        if (m_len - m_k == 0) begin
          m_run = 0; m_valid = 0; m_done = 1;
        end else begin
          m_data = int'(rom[(m_base + m_k) % NLOC]);
          m_valid = 1;
          m_k++;
          m_addr = (m_base + m_k) % NLOC;
        end
      end
    end
  end

  // Single compare process, plus logs of accepted words and done pulses.
  int acc_log[$];
  int acc_cyc[$];
  int done_cnt = 0, done_cyc = 0, valid_cnt = 0, busy_cnt = 0, cyc = 0;
  int prev_stall = 0, prev_data = 0;

  always @(negedge clk) begin
    if (chk_on && reset_n) begin
      chk("rom_addr", int'(bus.rom_addr), m_addr);
      chk("out_valid", int'(bus.out_valid), m_valid);
      chk("out_data", int'(bus.out_data), m_data);
      chk("busy", int'(bus.busy), m_run);
      chk("done", int'(bus.done), m_done);
      if (prev_stall != 0 && m_run != 0) begin
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_data", int'(bus.out_data), prev_data);
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_all_words_out", exp_q.size(), 0);
      end
      if (bus.out_valid) valid_cnt++;
      if (bus.busy) busy_cnt++;
      if (bus.out_valid && bus.out_ready && !bus.abort) begin
        if (exp_q.size() == 0) chk("unexpected_word", int'(bus.out_data), -1);
        else chk("word_order", int'(bus.out_data), exp_q.pop_front());
        acc_log.push_back(int'(bus.out_data));
        acc_cyc.push_back(cyc);
      end
      prev_stall = (bus.out_valid && !bus.out_ready && !bus.abort) ? 1 : 0;
      prev_data  = int'(bus.out_data);
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int b, input int l);
    bus.start = 1'b1;
    bus.base  = AW'(b);
    bus.len   = LW'(l);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!bus.busy && !bus.out_valid) return;
      tick();
    end
    chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic chk_words(input string name, input int n0, input int w0, input int w1,
                           input int w2, input int w3, input int n);
    int w[4];
    w = '{w0, w1, w2, w3};
    chk({name, "_count"}, acc_log.size() - n0, n);
    for (int i = 0; i < n; i++)
      if (n0 + i < acc_log.size()) chk({name, "_word"}, acc_log[n0 + i], w[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int n0, d0, v0, b0, g;
    int pat[7];
    bus.start = 1'b0; bus.abort = 1'b0; bus.base = '0; bus.len = '0; bus.out_ready = 1'b1;
    reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_rom_addr", int'(bus.rom_addr), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    reset_n = 1'b1;
    chk_on = 1'b1;
    tick();

    // base=3 len=4, ready high: 3,4,5,6 back to back, done right after last accept.
    n0 = acc_log.size(); d0 = done_cnt;
    pulse_start(3, 4);
    wait_idle(50); tick(); tick();
    chk_words("burst3", n0, 3, 4, 5, 6, 4);
    chk("burst3_done_cnt", done_cnt - d0, 1);
    if (acc_log.size() - n0 == 4) begin
      chk("burst3_back_to_back", acc_cyc[n0 + 3] - acc_cyc[n0], 3);
      chk("burst3_done_cycle", done_cyc, acc_cyc[n0 + 3] + 1);
    end

    // Wrap: base=14 len=4 -> 14,15,0,1.
    n0 = acc_log.size(); d0 = done_cnt;
    pulse_start(14, 4);
    wait_idle(50); tick(); tick();
    chk_words("wrap", n0, 14, 15, 0, 1, 4);
    chk("wrap_done_cnt", done_cnt - d0, 1);
    chk("wrap_addr_after", int'(bus.rom_addr), 2);

    // Backpressure pattern.
    n0 = acc_log.size(); d0 = done_cnt;
    pat = '{1, 0, 0, 1, 1, 0, 1};
    pulse_start(0, 3);
    for (int i = 0; i < 7; i++) begin
      bus.out_ready = pat[i][0];
      tick();
    end
    bus.out_ready = 1'b1;
    wait_idle(50); tick(); tick();
    chk_words("bp", n0, 0, 1, 2, 0, 3);
    chk("bp_done_cnt", done_cnt - d0, 1);

    // len=0: done only.
    d0 = done_cnt; v0 = valid_cnt; b0 = busy_cnt;
    pulse_start(5, 0);
    tick(); tick();
    chk("len0_done_cnt", done_cnt - d0, 1);
    chk("len0_valid_cycles", valid_cnt - v0, 0);
    chk("len0_busy_cycles", busy_cnt - b0, 0);

    // Abort after third acceptance, then a one-word burst from 9.
    n0 = acc_log.size(); d0 = done_cnt;
    pulse_start(2, 8);
    g = 0;
    while (acc_log.size() - n0 < 3 && g < 50) begin tick(); g++; end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_busy", int'(bus.busy), 0);
    tick(); tick();
    chk("abort_no_done", done_cnt - d0, 0);
    chk_words("abort", n0, 2, 3, 4, 0, 3);
    n0 = acc_log.size(); d0 = done_cnt;
    pulse_start(9, 1);
    wait_idle(50); tick(); tick();
    chk_words("after_abort", n0, 9, 0, 0, 0, 1);
    chk("after_abort_done", done_cnt - d0, 1);

    // Stalled burst, ignored start in RUN, then async reset between edges.
    bus.out_ready = 1'b0;
    pulse_start(5, 10);
    tick(); tick(); tick();
    pulse_start(1, 2);
    chk("run_start_ignored_addr", int'(bus.rom_addr), 6);
    chk("run_start_ignored_data", int'(bus.out_data), 5);
    d0 = done_cnt;
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_rom_addr", int'(bus.rom_addr), 0);
    chk("midrst_out_data", int'(bus.out_data), 0);
    chk("midrst_done", int'(bus.done), 0);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_stays_idle", int'(bus.busy), 0);

    // Randomized bursts with random backpressure, aborts and spurious starts.
    for (int b = 0; b < 40; b++) begin
      bus.base = AW'($urandom_range(0, NLOC - 1));
      bus.len  = LW'($urandom_range(0, NLOC));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 0; c < 120; c++) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        bus.abort = ($urandom_range(0, 39) == 0);
        bus.start = ($urandom_range(0, 4) == 0);
        bus.base  = AW'($urandom_range(0, NLOC - 1));
        bus.len   = LW'($urandom_range(0, NLOC));
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        if (!bus.busy && !bus.out_valid) break;
      end
    end
    bus.out_ready = 1'b1;
    wait_idle(100);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rom_streamer.md
ROM_STREAMER -- requirements
Module: rom_streamer

Interface
REQ-001 Parameter Nloc, default 16, number of ROM locations; any value >= 2, not required to be a power of 2.
REQ-002 Parameter Dbits, default 4, ROM data width.
REQ-003 Local AW = $clog2(Nloc); LW = $clog2(Nloc)+1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to begin a burst; sampled only in IDLE.
REQ-007 abort  input  1  terminate the current burst immediately.
REQ-008 base  input  AW  first ROM address of the burst; sampled with start.
REQ-009 len  input  LW  word count of the burst, 0..Nloc; sampled with start.
REQ-010 rom_addr  output  AW  address to the asynchronous-read ROM.
REQ-011 rom_dout  input  Dbits  ROM data for rom_addr, valid in the same cycle.
REQ-012 out_data  output  Dbits  streamed word, registered.
REQ-013 out_valid  output  1  out_data holds a word not yet accepted.
REQ-014 out_ready  input  1  consumer accepts out_data when high with out_valid.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  one-cycle pulse at normal burst completion.

Function
REQ-017 States: IDLE, RUN; state, ptr (AW), remaining (LW), out_data, out_valid, done are registers.
REQ-018 rom_addr shall equal ptr at all times; no combinational path from start, base or len to rom_addr.
REQ-019 IDLE, start=1, abort=0: ptr<=base, remaining<=len, state<=RUN; out_valid stays 0.
REQ-020 IDLE, start=1, len=0: state stays IDLE, done=1 next cycle, no word emitted.
REQ-021 Load condition in RUN: remaining!=0 and (out_valid==0 or out_ready==1).
REQ-022 On load: out_data<=rom_dout, out_valid<=1, remaining<=remaining-1, ptr<=(ptr==Nloc-1)?0:ptr+1.
REQ-023 In RUN with out_valid=1 and out_ready=1 and no load: out_valid<=0.
REQ-024 out_data and out_valid shall hold while out_valid=1 and out_ready=0 (no drop, no duplicate).
REQ-025 First word valid on the edge after the start edge; sustained throughput 1 word/cycle with out_ready held high.
REQ-026 RUN exits to IDLE on the edge where remaining==0 and the last word is accepted (out_valid&out_ready) or out_valid==0; done=1 for exactly the following cycle.
REQ-027 abort=1 in any state: state<=IDLE, out_valid<=0, remaining<=0, done stays 0; abort overrides start and any handshake in that cycle.
REQ-028 start while in RUN shall be ignored; base/len changes during RUN shall have no effect.
REQ-029 Address wrap: a burst crossing Nloc-1 continues at 0; len=Nloc reads every location exactly once.
REQ-030 In IDLE ptr holds its last value; out_data holds its last value.

Reset
REQ-031 reset_n=0 asynchronously forces state=IDLE, ptr=0 (rom_addr=0), remaining=0, out_data=0, out_valid=0, busy=0, done=0.
REQ-032 Reset asserted mid-burst discards the burst; no done pulse; after release the block waits in IDLE for start.

Verification
REQ-033 Nloc=16, ROM mem[i]=i; base=3, len=4, out_ready=1 -> out_data 3,4,5,6 on consecutive cycles from the cycle after start; done pulses once, the cycle after word 6 is accepted.
REQ-034 base=14, len=4, out_ready=1 -> words 14,15,0,1; rom_addr wraps 15->0.
REQ-035 base=0, len=3, out_ready toggling 1,0,0,1,1,0,1 -> exactly 0,1,2 accepted in order; out_data stable while out_ready=0.
REQ-036 start with len=0 -> out_valid never rises, busy stays 0, done=1 for one cycle.
REQ-037 base=2, len=8, abort asserted after 3rd acceptance -> out_valid=0 next cycle, busy=0, no done; new start base=9, len=1 then emits 9.
REQ-038 reset_n pulsed low mid-burst between edges -> outputs go to reset values immediately; start during RUN (before reset) ignored.
